// File: rtl/od_cfg_shifter.sv
// Serial configuration master for a TS4231-style sensor over two open-drain
// lines (E = clock/envelope, D = data). It writes a word MSB first. It can then
// read the word back and compare it with what was written. Both outputs are
// active-low drive requests: 1 releases the pin and 0 pulls it low.
module od_cfg_shifter #(
    parameter int HALF_PERIOD = 8,
    parameter int CFG_WIDTH   = 15,
    parameter int VERIFY      = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CFG_WIDTH-1:0] cfg_word,
    output logic                 e_dout,
    output logic                 d_dout,
    input  logic                 e_din,
    input  logic                 d_din,
    output logic                 busy,
    output logic                 done,
    output logic                 ok,
    output logic                 err_stuck,
    output logic [CFG_WIDTH-1:0] rb_word
);

    localparam int TW = $clog2(HALF_PERIOD);
    localparam int BW = $clog2(CFG_WIDTH);
    localparam logic [TW-1:0] T_LAST = TW'(HALF_PERIOD - 1);
    localparam logic [BW-1:0] B_TOP  = BW'(CFG_WIDTH - 1);

    typedef enum logic [3:0] {
        IDLE, WR_START_D, WR_START_E, WR_LOW, WR_HIGH,
        STOP_A, STOP_B, STOP_C, RB_START, RB_LOW, RB_HIGH, FINISH
    } state_t;

    state_t               state_reg, state_next;
    logic [TW-1:0]        timer_reg;
    logic [BW-1:0]        bit_reg, bit_next;
    logic [CFG_WIDTH-1:0] cfg_reg, cfg_next;
    logic [CFG_WIDTH-1:0] rb_word_reg, rb_word_next;
    logic                 rb_phase_reg, rb_phase_next;
    logic                 ok_reg, ok_next;
    logic                 err_stuck_reg, err_stuck_next;
    logic [1:0]           e_sync_reg, d_sync_reg;
    logic                 e_dout_reg, d_dout_reg, e_level, d_level;
    logic                 busy_reg, done_reg;
    logic                 stuck_fail;

    // Synchronized pin levels; only ever looked at in the last cycle of a phase
    logic e_s, d_s, phase_end;
    assign e_s       = e_sync_reg[1];
    assign d_s       = d_sync_reg[1];
    assign phase_end = (timer_reg == T_LAST);

    // Next-state, bit sequencing, readback capture and stuck-line detection
    always_comb begin
        state_next     = state_reg;
        bit_next       = bit_reg;
        cfg_next       = cfg_reg;
        rb_phase_next  = rb_phase_reg;
        rb_word_next   = rb_word_reg;
        ok_next        = ok_reg;
        err_stuck_next = err_stuck_reg;
        stuck_fail     = 1'b0;
        case (state_reg)
            IDLE: if (start) begin
                state_next     = WR_START_D;
                cfg_next       = cfg_word;
                bit_next       = B_TOP;
                rb_phase_next  = 1'b0;
                ok_next        = 1'b0;
                err_stuck_next = 1'b0;
                rb_word_next   = '0;
            end
            WR_START_D: if (phase_end) state_next = WR_START_E;
            WR_START_E: if (phase_end) state_next = WR_LOW;
            WR_LOW:     if (phase_end) state_next = WR_HIGH;
            WR_HIGH: if (phase_end) begin
                // A released E, or a released D while sending a 1, must read high
                if (!e_s || (cfg_reg[bit_reg] && !d_s)) begin
                    stuck_fail = 1'b1;
                end else if (bit_reg == '0) begin
                    state_next = STOP_A;
                end else begin
                    bit_next   = bit_reg - BW'(1);
                    state_next = WR_LOW;
                end
            end
            STOP_A: if (phase_end) state_next = STOP_B;
            STOP_B: if (phase_end) state_next = STOP_C;
            STOP_C: if (phase_end) begin
                if (!e_s || !d_s) begin
                    stuck_fail = 1'b1;
                end else if (!rb_phase_reg && (VERIFY != 0)) begin
                    state_next    = RB_START;
                    rb_phase_next = 1'b1;
                    bit_next      = B_TOP;
                end else begin
                    state_next = FINISH;
                end
            end
            RB_START: if (phase_end) state_next = RB_LOW;
            RB_LOW:   if (phase_end) state_next = RB_HIGH;
            RB_HIGH: if (phase_end) begin
                rb_word_next[bit_reg] = d_s;
                if (!e_s) begin
                    stuck_fail = 1'b1;
                end else if (bit_reg == '0) begin
                    state_next = STOP_A;
                end else begin
                    bit_next   = bit_reg - BW'(1);
                    state_next = RB_LOW;
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (stuck_fail) begin
            err_stuck_next = 1'b1;
            state_next     = FINISH;
        end
        // Result is settled on the edge that enters FINISH so it is valid with done
        if (state_next == FINISH && state_reg != FINISH) begin
            ok_next = !stuck_fail && ((VERIFY == 0) || (rb_word_next == cfg_reg));
        end
    end

    // Line levels belonging to the state being entered, so the registered
    // outputs change in the first cycle of each state
    always_comb begin
        e_level = 1'b1;
        d_level = 1'b1;
        case (state_next)
            WR_START_D: begin e_level = 1'b1; d_level = 1'b0;                end
            WR_START_E: begin e_level = 1'b0; d_level = 1'b0;                end
            WR_LOW:     begin e_level = 1'b0; d_level = cfg_next[bit_next];  end
            WR_HIGH:    begin e_level = 1'b1; d_level = cfg_next[bit_next];  end
            STOP_A:     begin e_level = 1'b0; d_level = 1'b0;                end
            STOP_B:     begin e_level = 1'b1; d_level = 1'b0;                end
            RB_START,
            RB_LOW:     begin e_level = 1'b0; d_level = 1'b1;                end
            default:    begin e_level = 1'b1; d_level = 1'b1;                end
        endcase
    end

    // State, phase timer, synchronizers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            timer_reg     <= '0;
            bit_reg       <= '0;
            cfg_reg       <= '0;
            rb_word_reg   <= '0;
            rb_phase_reg  <= 1'b0;
            ok_reg        <= 1'b0;
            err_stuck_reg <= 1'b0;
            e_sync_reg    <= 2'b11;
            d_sync_reg    <= 2'b11;
            e_dout_reg    <= 1'b1;
            d_dout_reg    <= 1'b1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            timer_reg     <= (state_next != state_reg || state_reg == IDLE) ? '0 : timer_reg + TW'(1);
            bit_reg       <= bit_next;
            cfg_reg       <= cfg_next;
            rb_word_reg   <= rb_word_next;
            rb_phase_reg  <= rb_phase_next;
            ok_reg        <= ok_next;
            err_stuck_reg <= err_stuck_next;
            e_sync_reg    <= {e_sync_reg[0], e_din};
            d_sync_reg    <= {d_sync_reg[0], d_din};
            e_dout_reg    <= e_level;
            d_dout_reg    <= d_level;
            busy_reg      <= (state_next != IDLE);
            done_reg      <= (state_next == FINISH);
        end
    end

    assign e_dout    = e_dout_reg;
    assign d_dout    = d_dout_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign ok        = ok_reg;
    assign err_stuck = err_stuck_reg;
    assign rb_word   = rb_word_reg;

endmodule

// File: doc/od_cfg_shifter.md
Name: od_cfg_shifter

Overview:
- Serial configuration master that drives two open-drain lines, E (clock/envelope) and D (data), toward a TS4231-style light sensor through the open-drain IO cells.
- Writes a CFG_WIDTH-bit word MSB first, then optionally reads it back and compares it against the written word.
- Outputs are active-low drive requests (1 = release the pin, 0 = pull it low) and connect directly to the IO cell DOUT0 inputs.
- Pin readback from the IO cell DIN0 outputs passes through an internal 2-flop synchronizer.

Parameters:
- HALF_PERIOD, 8: clock cycles per protocol phase. Legal range is 4 or more.
- CFG_WIDTH, 15: configuration word width in bits. Legal range is 2 to 16.
- VERIFY, 1: 1 = run readback and compare after the write; 0 = finish after the write stop.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- cfg_word  in  CFG_WIDTH  word to write; latched on an accepted start
- e_dout  out  1  E drive request (0 = pull low, 1 = release)
- d_dout  out  1  D drive request (0 = pull low, 1 = release)
- e_din  in  1  E pin level (asynchronous)
- d_din  in  1  D pin level (asynchronous)
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- ok  out  1  valid with done, held until the next start: no error and readback matched (or VERIFY=0)
- err_stuck  out  1  valid with done, held: a released line read low
- rb_word  out  CFG_WIDTH  word read back; holds its value until the next start

Behaviour:
- Reset values: e_dout=1, d_dout=1, busy=0, done=0, ok=0, err_stuck=0, rb_word=0, state=IDLE, synchronizers=1.
- Reset mid-operation: both lines are released at the clock edge where reset is sampled high. No done pulse is generated.
- Phase timer counts HALF_PERIOD cycles per state, then advances the state. The bit counter runs from CFG_WIDTH-1 down to 0.
- Synchronizers: e_s and d_s are 2-flop synchronized copies of e_din and d_din. Every sample in this section uses the synced value taken in the last cycle of a phase.
- States and line levels, given as (E, D):
  - IDLE (1,1). start accepted -> latch cfg_word, clear ok, err_stuck and rb_word -> WR_START_D.
  - WR_START_D (1,0) -> WR_START_E.
  - WR_START_E (0,0) -> WR_LOW.
  - WR_LOW (0, cfg[bit]) -> WR_HIGH.
  - WR_HIGH (1, cfg[bit]).
    - Stuck check at phase end: e_s must be 1. If cfg[bit]=1, d_s must also be 1.
    - Exit: if bit=0 -> STOP_A; otherwise decrement bit -> WR_LOW.
  - STOP_A (0,0) -> STOP_B.
  - STOP_B (1,0) -> STOP_C.
  - STOP_C (1,1). Stuck check on both lines at phase end.
    - Exit after the write: to RB_START if VERIFY=1, otherwise to FINISH.
    - Exit after the readback: to FINISH.
  - RB_START (0,1). Reload the bit counter -> RB_LOW.
  - RB_LOW (0,1) -> RB_HIGH.
  - RB_HIGH (1,1).
    - At phase end: rb_word[bit] <= d_s. Stuck check: e_s must be 1.
    - Exit: if bit=0 -> STOP_A; otherwise decrement bit -> RB_LOW.
  - FINISH: one cycle. done=1. ok = !err_stuck && (VERIFY==0 || rb_word==latched cfg). busy=0 next cycle -> IDLE.
- Stuck failure: any failed stuck check sets err_stuck=1, releases both lines immediately and jumps to FINISH (ok=0). The rest of the sequence is skipped.
- Line output timing: e_dout and d_dout are registered and take their new levels in the first cycle of each state.
- start is ignored while busy or in FINISH. start together with reset is ignored.
- Write duration with VERIFY=0: (2 + 2·CFG_WIDTH + 3)·HALF_PERIOD + 1 cycles from the accepted start to done.
- VERIFY=1 adds (1 + 2·CFG_WIDTH + 3)·HALF_PERIOD cycles.

Test Plan:
- Write, no verify: VERIFY=0, HALF_PERIOD=4, cfg_word=15'h392B, pull-up model on both lines.
  - D is sampled at each rising edge of E and yields 0111001 00101011 MSB first.
  - done occurs 4·35+1=141 cycles after start, with ok=1 and err_stuck=0.
- Write then verify, matching: VERIFY=1, and the sensor model stores the word and drives D low for 0-bits during the readback E-high phases.
  - Required: rb_word=15'h392B, done with ok=1.
- Verify mismatch: sensor model returns 15'h392A.
  - Required: rb_word=15'h392A, ok=0, err_stuck=0.
- Stuck D: model holds D low permanently, cfg_word=15'h4000.
  - Required: the first WR_HIGH phase fails the check, done with err_stuck=1 and ok=0.
  - Both lines are released within 1 cycle of the failure.
- Reset mid-operation: assert reset during bit 7 of the write.
  - Required: next cycle e_dout=1, d_dout=1, busy=0, with no done pulse.
  - A new start of 15'h0001 afterwards completes with ok=1.
- start while busy: pulse start with cfg_word=15'h7FFF mid-write of 15'h392B.
  - Required: the pulse is ignored, the transmitted word stays 15'h392B, and exactly one done pulse occurs.
